// File: rtl/adp_types.sv
// Shared types for the ADP boundary-scan sequencer.
// Chain length, opcode and state encodings.
package adp_types;

  localparam int NUM_BOUNDARY_CELLS = 49;

  typedef enum logic [1:0] {
    OP_SAMPLE  = 2'b00,
    OP_EXTEST  = 2'b01,
    OP_RELEASE = 2'b10,
    OP_RSVD    = 2'b11
  } bscan_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SHIFT,
    ST_UPDATE,
    ST_RSP
  } bscan_state_e;

endpackage

// File: rtl/adp_bscan_sreg.sv
// PISO/SIPO pair: tx shifts out MSB first, rx shifts in at LSB.
// Ports: load/load_data, shift_en, serial_in -> serial_out, par_out.
module adp_bscan_sreg #(
  parameter int W = 49
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         serial_in,
  output logic         serial_out,
  output logic [W-1:0] par_out
);

  logic [W-1:0] tx_sreg;
  logic [W-1:0] rx_sreg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sreg <= '0;
      rx_sreg <= '0;
    end else if (load) begin
      tx_sreg <= load_data;
      rx_sreg <= '0;
    end else if (shift_en) begin
      tx_sreg <= {tx_sreg[W-2:0], 1'b0};
      rx_sreg <= {rx_sreg[W-2:0], serial_in};
    end
  end

  assign serial_out = tx_sreg[W-1];
  assign par_out    = rx_sreg;

endmodule

// File: rtl/adp_bscan_ctrl.sv
// Boundary-scan chain sequencer: capture/shift/update per command.
// Ports: cmd_* request, rsp_* response, adp_bscan_* chain controls.
import adp_types::*;

module adp_bscan_ctrl #(
  parameter int NUM_BOUNDARY_CELLS = adp_types::NUM_BOUNDARY_CELLS
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_op,
  input  logic [NUM_BOUNDARY_CELLS-1:0] cmd_data,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [NUM_BOUNDARY_CELLS-1:0] rsp_data,
  output logic                          rsp_err,
  output logic                          adp_bscan_start,
  input  logic                          adp_bscan_end,
  output logic                          adp_bscan_se,
  output logic                          adp_bscan_shift_sel,
  output logic                          adp_bscan_oe,
  output logic                          adp_bscan_out_sel
);

  localparam int N  = NUM_BOUNDARY_CELLS;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  bscan_state_e  state_q;
  bscan_state_e  state_d;
  bscan_op_e     op_q;
  logic          err_q;
  logic          out_sel_q;
  logic [CW-1:0] cnt_q;
  logic          hs;
  logic          tx_msb;

  assign hs = cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op == OP_SAMPLE || cmd_op == OP_EXTEST)
            state_d = ST_CAPTURE;
          else
            state_d = ST_RSP;
        end
      end
      ST_CAPTURE: state_d = ST_SHIFT;
      ST_SHIFT: begin
        if (cnt_q == CNT_LAST)
          state_d = (op_q == OP_EXTEST) ? ST_UPDATE : ST_RSP;
      end
      ST_UPDATE: state_d = ST_RSP;
      ST_RSP: begin
        if (rsp_ready)
          state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_SAMPLE;
      err_q     <= 1'b0;
      out_sel_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      if (hs) begin
        op_q  <= bscan_op_e'(cmd_op);
        err_q <= (cmd_op == OP_RSVD);
        if (cmd_op == OP_RELEASE)
          out_sel_q <= 1'b0;
      end
      if (state_q == ST_CAPTURE)
        cnt_q <= '0;
      else if (state_q == ST_SHIFT)
        cnt_q <= cnt_q + 1'b1;
      if (state_q == ST_UPDATE)
        out_sel_q <= 1'b1;
    end
  end

  adp_bscan_sreg #(
    .W (N)
  ) u_sreg (
    .clk        (clk),
    .rst        (rst),
    .load       (hs),
    .load_data  (cmd_data),
    .shift_en   (state_q == ST_SHIFT),
    .serial_in  (adp_bscan_end),
    .serial_out (tx_msb),
    .par_out    (rsp_data)
  );

  // Chain controls depend on registered state only.
  assign cmd_ready           = (state_q == ST_IDLE);
  assign rsp_valid           = (state_q == ST_RSP);
  assign rsp_err             = (state_q == ST_RSP) && err_q;
  assign adp_bscan_se        = (state_q == ST_CAPTURE) ||
                               (state_q == ST_SHIFT);
  assign adp_bscan_shift_sel = (state_q == ST_SHIFT);
  assign adp_bscan_start     = (state_q == ST_SHIFT) && tx_msb;
  assign adp_bscan_oe        = (state_q == ST_UPDATE);
  assign adp_bscan_out_sel   = out_sel_q;

endmodule

// File: tb/tb_adp_bscan_ctrl.sv
// Directed bench for adp_bscan_ctrl with a behavioural chain model.
// Checks latency, loaded/captured vectors, out_sel, oe/se activity, reset.
module tb_adp_bscan_ctrl;

  localparam int N = 49;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'b00;
  logic [N-1:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [N-1:0] rsp_data;
  logic         rsp_err;
  logic         bs_start;
  logic         bs_end;
  logic         bs_se;
  logic         bs_shift_sel;
  logic         bs_oe;
  logic         bs_out_sel;

  int n_assert = 0;
  int n_fail   = 0;
  int oe_hi    = 0;
  int se_hi    = 0;

  always #5 clk = ~clk;

  adp_bscan_ctrl #(.NUM_BOUNDARY_CELLS(N)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .cmd_valid           (cmd_valid),
    .cmd_ready           (cmd_ready),
    .cmd_op              (cmd_op),
    .cmd_data            (cmd_data),
    .rsp_valid           (rsp_valid),
    .rsp_ready           (rsp_ready),
    .rsp_data            (rsp_data),
    .rsp_err             (rsp_err),
    .adp_bscan_start     (bs_start),
    .adp_bscan_end       (bs_end),
    .adp_bscan_se        (bs_se),
    .adp_bscan_shift_sel (bs_shift_sel),
    .adp_bscan_oe        (bs_oe),
    .adp_bscan_out_sel   (bs_out_sel)
  );

  // Chain model: capture flops form the shift path, update flops drive pins.
  logic [N-1:0] cap  = '0;
  logic [N-1:0] upd  = '0;
  logic [N-1:0] pins = '0;

  assign bs_end = cap[N-1];

  always @(posedge clk) begin
    if (bs_se)
      cap <= bs_shift_sel ? {cap[N-2:0], bs_start} : pins;
    if (bs_oe)
      upd <= cap;
    if (bs_oe)
      oe_hi <= oe_hi + 1;
    if (bs_se)
      se_hi <= se_hi + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Handshake a command, return the cycle rsp_valid is first seen.
  task automatic issue(input logic [1:0] op, input logic [N-1:0] d,
                       output int cyc);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  localparam logic [N-1:0] D1 = 49'h1_5555_5555_5555;
  localparam logic [N-1:0] P1 = 49'h0_1234_5678_9ABC;
  localparam logic [N-1:0] D2 = 49'h0_FFFF_0000_FFFF;
  localparam logic [N-1:0] P2 = 49'h0_F0F0_0000_A5A5;
  localparam logic [N-1:0] D3 = 49'h1_0000_CAFE_0001;
  localparam logic [N-1:0] P3 = 49'h1_8000_0000_0007;

  initial begin
    int cyc;
    int oe0;
    int se0;
    int seen;
    logic [N-1:0] hold;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_chain",
        {bs_start, bs_se, bs_shift_sel, bs_oe, bs_out_sel}, 0);
    rst = 1'b0;
    @(negedge clk);

    pins = P1;
    oe0  = oe_hi;
    issue(2'b01, D1, cyc);
    chk("extest_latency", cyc, 52);
    chk("extest_rsp_data", rsp_data, P1);
    chk("extest_upd", upd, D1);
    chk("extest_out_sel", bs_out_sel, 1);
    chk("extest_oe_cycles", oe_hi - oe0, 1);

    hold = rsp_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_stable",
          {rsp_valid, cmd_ready, (rsp_data == hold)}, 3'b101);
    end
    consume();
    chk("after_consume", {rsp_valid, cmd_ready}, 2'b01);

    pins = P2;
    oe0  = oe_hi;
    issue(2'b00, D2, cyc);
    chk("sample_latency", cyc, 51);
    chk("sample_rsp_data", rsp_data, P2);
    chk("sample_no_oe", oe_hi - oe0, 0);
    chk("sample_out_sel", bs_out_sel, 1);
    chk("sample_upd_kept", upd, D1);
    consume();

    issue(2'b10, D2, cyc);
    chk("release_latency", cyc, 1);
    chk("release_out_sel", bs_out_sel, 0);
    chk("release_rsp", {rsp_err, rsp_data}, 0);
    consume();

    oe0 = oe_hi;
    se0 = se_hi;
    issue(2'b11, D1, cyc);
    chk("rsvd_latency", cyc, 1);
    chk("rsvd_err", rsp_err, 1);
    chk("rsvd_rsp_data", rsp_data, 0);
    consume();
    chk("rsvd_no_se_oe", {se_hi - se0, oe_hi - oe0}, 0);
    chk("rsvd_err_clear", rsp_err, 0);

    pins = P1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b01;
    cmd_data  = D1;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_shift", {bs_se, bs_shift_sel}, 2'b11);
    #2 rst = 1'b1;
    #1;
    chk("abort_cmd_ready", cmd_ready, 1);
    chk("abort_rsp", {rsp_valid, rsp_err}, 0);
    chk("abort_rsp_data", rsp_data, 0);
    chk("abort_chain",
        {bs_start, bs_se, bs_shift_sel, bs_oe, bs_out_sel}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("abort_no_rsp", seen, 0);

    pins = P3;
    issue(2'b01, D3, cyc);
    chk("recover_latency", cyc, 52);
    chk("recover_rsp_data", rsp_data, P3);
    chk("recover_upd", upd, D3);
    chk("recover_out_sel", bs_out_sel, 1);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
